// File: rtl/td4_fetch_sequencer.sv
// td4_fetch_sequencer
//   Reader side of the TD4 program counter. Takes the current PC, fetches one
//   instruction word from the ROM over a REQ/ACK handshake, latches it into
//   the instruction register, and pulses PC_INC once the execute stage
//   reports completion.
//
// Optional feature (compile-time macro TD4_FETCH_TIMEOUT_EN):
//   A ROM fetch that sees TIMEOUT_CYC consecutive ACK-low cycles is abandoned.
//   ROM_REQ drops and FETCH_ERR is set and held until CLR. While FETCH_ERR is
//   set, no new fetch starts. Without the macro, REQ waits forever and
//   FETCH_ERR is tied low.
//
// Ports:
//   CLK        in   system clock, rising edge
//   CLR        in   asynchronous active-high reset
//   RUN        in   level, enables starting a new fetch
//   PC         in   current program counter value
//   ROM_ADDR   out  registered fetch address (held for the whole request)
//   ROM_REQ    out  fetch request, held until acknowledged
//   ROM_ACK    in   ROM data valid (sampled only while requesting)
//   ROM_DATA   in   instruction word
//   IR         out  instruction register
//   OPCODE     out  IR upper half
//   IMM        out  IR lower half
//   IR_VALID   out  one-cycle pulse after IR is loaded
//   EXEC_DONE  in   execute stage finished the current instruction
//   PC_INC     out  one-cycle pulse telling the counter to advance
//   BUSY       out  high whenever the sequencer is not idle
//   FETCH_ERR  out  sticky ROM timeout flag (optional feature only)

module td4_fetch_sequencer #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                RUN,
    input  logic [ADDR_W-1:0]   PC,
    output logic [ADDR_W-1:0]   ROM_ADDR,
    output logic                ROM_REQ,
    input  logic                ROM_ACK,
    input  logic [DATA_W-1:0]   ROM_DATA,
    output logic [DATA_W-1:0]   IR,
    output logic [DATA_W/2-1:0] OPCODE,
    output logic [DATA_W/2-1:0] IMM,
    output logic                IR_VALID,
    input  logic                EXEC_DONE,
    output logic                PC_INC,
    output logic                BUSY,
    output logic                FETCH_ERR
);

    if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255) begin : g_timeout_range
        $error("TIMEOUT_CYC must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        EXEC
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic                req_q, req_nxt;
    logic [DATA_W-1:0]   ir_q, ir_nxt;
    logic                valid_q, valid_nxt;
    logic                inc_q, inc_nxt;
    logic                busy_q, busy_nxt;
    logic                start;

`ifdef TD4_FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] tcnt, tcnt_nxt;
    logic       err_q, err_nxt;

    assign start = RUN && !inc_q && !err_q;
`else
    // A new fetch is held off while PC_INC is high: the counter only applies
    // the increment on the following edge, so sampling PC any earlier would
    // refetch the old address.
    assign start = RUN && !inc_q;
`endif

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state   <= IDLE;
            addr_q  <= '0;
            req_q   <= 1'b0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef TD4_FETCH_TIMEOUT_EN
            tcnt    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            req_q   <= req_nxt;
            ir_q    <= ir_nxt;
            valid_q <= valid_nxt;
            inc_q   <= inc_nxt;
            busy_q  <= busy_nxt;
`ifdef TD4_FETCH_TIMEOUT_EN
            tcnt    <= tcnt_nxt;
            err_q   <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        req_nxt   = req_q;
        ir_nxt    = ir_q;
        valid_nxt = 1'b0;
        inc_nxt   = 1'b0;
`ifdef TD4_FETCH_TIMEOUT_EN
        tcnt_nxt  = tcnt;
        err_nxt   = err_q;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    addr_nxt  = PC;
                    req_nxt   = 1'b1;
                    state_nxt = REQ;
`ifdef TD4_FETCH_TIMEOUT_EN
                    tcnt_nxt  = '0;
`endif
                end
            end
            REQ: begin
                if (ROM_ACK) begin
                    ir_nxt    = ROM_DATA;
                    req_nxt   = 1'b0;
                    valid_nxt = 1'b1;
                    state_nxt = EXEC;
                end
`ifdef TD4_FETCH_TIMEOUT_EN
                // The TIMEOUT_CYC-th consecutive ACK-low cycle abandons the fetch.
                else if (tcnt == TIMEOUT_LAST) begin
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt  = tcnt + 8'd1;
                end
`endif
            end
            EXEC: begin
                // EXEC_DONE is first sampled on the edge that closes the
                // IR_VALID cycle; any level present at the ACK edge is dropped.
                if (EXEC_DONE) begin
                    inc_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    assign ROM_ADDR = addr_q;
    assign ROM_REQ  = req_q;
    assign IR       = ir_q;
    assign OPCODE   = ir_q[DATA_W-1:DATA_W/2];
    assign IMM      = ir_q[DATA_W/2-1:0];
    assign IR_VALID = valid_q;
    assign PC_INC   = inc_q;
    assign BUSY     = busy_q;
`ifdef TD4_FETCH_TIMEOUT_EN
    assign FETCH_ERR = err_q;
`else
    assign FETCH_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_td4_fetch_sequencer.sv
// tb_td4_fetch_sequencer
//   Directed bench for td4_fetch_sequencer. A transaction-level reference
//   ("fetch open", "instruction open") is compared against the DUT on every
//   falling edge; directed steps add hand-computed literal expectations.
//   Build with TD4_FETCH_TIMEOUT_EN defined to exercise the ROM timeout.

module tb_td4_fetch_sequencer;

`ifdef TD4_FETCH_TIMEOUT_EN
    localparam int unsigned TCYC  = 4;
    localparam bit          TO_EN = 1'b1;
    localparam int unsigned SLOW  = 3;
`else
    localparam int unsigned TCYC  = 15;
    localparam bit          TO_EN = 1'b0;
    localparam int unsigned SLOW  = 5;
`endif

    logic       clk, clr, run, rom_ack, exec_done;
    logic [3:0] pc, rom_addr, opcode, imm;
    logic [7:0] rom_data, ir;
    logic       rom_req, ir_valid, pc_inc, busy, fetch_err;

    int total = 0;
    int bad   = 0;

    td4_fetch_sequencer #(
        .ADDR_W      (4),
        .DATA_W      (8),
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .CLK       (clk),
        .CLR       (clr),
        .RUN       (run),
        .PC        (pc),
        .ROM_ADDR  (rom_addr),
        .ROM_REQ   (rom_req),
        .ROM_ACK   (rom_ack),
        .ROM_DATA  (rom_data),
        .IR        (ir),
        .OPCODE    (opcode),
        .IMM       (imm),
        .IR_VALID  (ir_valid),
        .EXEC_DONE (exec_done),
        .PC_INC    (pc_inc),
        .BUSY      (busy),
        .FETCH_ERR (fetch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a fetch is open from its start edge until ACK (or
    // timeout); an instruction is open from ACK until EXEC_DONE is accepted.
    // New fetches need RUN, no error, and no increment pulse still in flight.
    logic [3:0]  m_addr;
    logic [7:0]  m_ir;
    bit          m_fetch_open, m_instr_open, m_valid, m_inc, m_err;
    int unsigned m_miss;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_addr       <= 4'h0;
            m_ir         <= 8'h00;
            m_fetch_open <= 1'b0;
            m_instr_open <= 1'b0;
            m_valid      <= 1'b0;
            m_inc        <= 1'b0;
            m_err        <= 1'b0;
            m_miss       <= 0;
        end else begin
            m_valid <= 1'b0;
            m_inc   <= 1'b0;
            if (m_fetch_open) begin
                if (rom_ack) begin
                    m_ir         <= rom_data;
                    m_fetch_open <= 1'b0;
                    m_instr_open <= 1'b1;
                    m_valid      <= 1'b1;
                end else if (TO_EN) begin
                    m_miss <= m_miss + 1;
                    if (m_miss + 1 == TCYC) begin
                        m_fetch_open <= 1'b0;
                        m_err        <= 1'b1;
                    end
                end
            end else if (m_instr_open) begin
                if (exec_done) begin
                    m_instr_open <= 1'b0;
                    m_inc        <= 1'b1;
                end
            end else if (run && !m_inc && !m_err) begin
                m_addr       <= pc;
                m_fetch_open <= 1'b1;
                m_miss       <= 0;
            end
        end
    end

    always @(negedge clk) begin
        check("m_rom_addr",  32'(rom_addr),  32'(m_addr));
        check("m_rom_req",   32'(rom_req),   32'(m_fetch_open));
        check("m_ir",        32'(ir),        32'(m_ir));
        check("m_opcode",    32'(opcode),    32'(m_ir) / 32'd16);
        check("m_imm",       32'(imm),       32'(m_ir) % 32'd16);
        check("m_ir_valid",  32'(ir_valid),  32'(m_valid));
        check("m_pc_inc",    32'(pc_inc),    32'(m_inc));
        check("m_busy",      32'(busy),      32'(m_fetch_open || m_instr_open));
        check("m_fetch_err", 32'(fetch_err), 32'(m_err));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    logic [3:0] exp_addr [4] = '{4'hE, 4'hF, 4'h0, 4'h1};
    logic [3:0] start_addr [$];
    int         start_cyc [$];
    bit         prev_req, inc_seen;

    initial begin
        // 1. Reset with RUN and ACK high
        clr = 1'b1; run = 1'b1; rom_ack = 1'b1; rom_data = 8'hA5;
        pc = 4'h5; exec_done = 1'b0;
        step(2);
        check("t1_rst_req",   32'(rom_req),   32'd0);
        check("t1_rst_addr",  32'(rom_addr),  32'd0);
        check("t1_rst_ir",    32'(ir),        32'd0);
        check("t1_rst_valid", 32'(ir_valid),  32'd0);
        check("t1_rst_inc",   32'(pc_inc),    32'd0);
        check("t1_rst_busy",  32'(busy),      32'd0);
        check("t1_rst_err",   32'(fetch_err), 32'd0);
        clr = 1'b0; rom_ack = 1'b0;
        step(1);
        check("t1_req",  32'(rom_req),  32'd1);
        check("t1_addr", 32'(rom_addr), 32'h5);
        check("t1_busy", 32'(busy),     32'd1);
        rom_ack = 1'b1; rom_data = 8'h5C; run = 1'b0;
        step(1);
        check("t1_ir", 32'(ir), 32'h5C);
        rom_ack = 1'b0; exec_done = 1'b1;
        step(1);
        check("t1_inc", 32'(pc_inc), 32'd1);
        exec_done = 1'b0;
        step(2);

        // 2. Single fetch, immediate ACK, EXEC_DONE held high
        pc = 4'h3; rom_data = 8'hB7; rom_ack = 1'b1; exec_done = 1'b1; run = 1'b1;
        step(1);
        check("t2_e0_req",  32'(rom_req),  32'd1);
        check("t2_e0_addr", 32'(rom_addr), 32'h3);
        check("t2_e0_inc",  32'(pc_inc),   32'd0);
        run = 1'b0;
        step(1);
        check("t2_e1_ir",     32'(ir),       32'hB7);
        check("t2_e1_opcode", 32'(opcode),   32'hB);
        check("t2_e1_imm",    32'(imm),      32'h7);
        check("t2_e1_valid",  32'(ir_valid), 32'd1);
        check("t2_e1_inc",    32'(pc_inc),   32'd0);
        step(1);
        check("t2_e2_valid", 32'(ir_valid), 32'd0);
        check("t2_e2_inc",   32'(pc_inc),   32'd1);
        step(1);
        check("t2_e3_inc",  32'(pc_inc),  32'd0);
        check("t2_e3_busy", 32'(busy),    32'd0);
        check("t2_e3_req",  32'(rom_req), 32'd0);
        exec_done = 1'b0; rom_ack = 1'b0;
        step(1);

        // 3. Slow ROM, PC moves during REQ, early EXEC_DONE
        pc = 4'h3; run = 1'b1;
        step(1);
        run = 1'b0; pc = 4'h9; exec_done = 1'b1;
        for (int i = 0; i < int'(SLOW); i++) begin
            step(1);
            check("t3_req_hold",  32'(rom_req),  32'd1);
            check("t3_addr_hold", 32'(rom_addr), 32'h3);
            check("t3_no_inc",    32'(pc_inc),   32'd0);
        end
        rom_ack = 1'b1; rom_data = 8'h4E;
        step(1);
        check("t3_ir",    32'(ir),       32'h4E);
        check("t3_valid", 32'(ir_valid), 32'd1);
        check("t3_inc0",  32'(pc_inc),   32'd0);
        rom_ack = 1'b0; exec_done = 1'b0;
        step(1);
        check("t3_inc1", 32'(pc_inc), 32'd0);
        check("t3_busy", 32'(busy),   32'd1);
        exec_done = 1'b1;
        step(1);
        check("t3_inc2", 32'(pc_inc), 32'd1);
        exec_done = 1'b0;
        step(1);

        // 4. Run loop with counter model and PC wrap
        pc = 4'hE; run = 1'b1; exec_done = 1'b1; rom_ack = 1'b0;
        prev_req = 1'b0; inc_seen = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step(1);
            if (inc_seen) pc = pc + 4'd1;
            inc_seen = pc_inc;
            if (rom_req && !prev_req) begin
                start_addr.push_back(rom_addr);
                start_cyc.push_back(c);
            end
            prev_req = rom_req;
            rom_ack  = rom_req;
            rom_data = {4'h1, rom_addr};
        end
        check("t4_starts", 32'(start_addr.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < start_addr.size(); k++) begin
            check("t4_addr", 32'(start_addr[k]), 32'(exp_addr[k]));
            if (k > 0) check("t4_period", 32'(start_cyc[k] - start_cyc[k-1]), 32'd4);
        end
        run = 1'b0;
        for (int d = 0; d < 10; d++) begin
            step(1);
            rom_ack = rom_req;
        end
        check("t4_idle", 32'(busy), 32'd0);
        exec_done = 1'b0; rom_ack = 1'b0;

        // 5a. CLR during REQ
        pc = 4'h6; run = 1'b1;
        step(1);
        run = 1'b0;
        #1 clr = 1'b1;
        #1;
        check("t5a_req",  32'(rom_req),  32'd0);
        check("t5a_busy", 32'(busy),     32'd0);
        check("t5a_addr", 32'(rom_addr), 32'd0);
        clr = 1'b0; exec_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t5a_no_inc", 32'(pc_inc), 32'd0);
        end
        exec_done = 1'b0;

        // 5b. CLR during EXEC
        pc = 4'h7; run = 1'b1; rom_ack = 1'b1; rom_data = 8'hC3;
        step(1);
        run = 1'b0;
        step(1);
        check("t5b_ir", 32'(ir), 32'hC3);
        rom_ack = 1'b0;
        #1 clr = 1'b1;
        #1;
        check("t5b_ir_clr", 32'(ir),       32'd0);
        check("t5b_busy",   32'(busy),     32'd0);
        check("t5b_valid",  32'(ir_valid), 32'd0);
        clr = 1'b0; exec_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t5b_no_inc", 32'(pc_inc), 32'd0);
        end
        exec_done = 1'b0;

        // 5c. RUN dropped during EXEC
        pc = 4'h8; run = 1'b1; rom_ack = 1'b1; rom_data = 8'h2D;
        step(2);
        run = 1'b0; rom_ack = 1'b0;
        step(1);
        check("t5c_busy", 32'(busy),   32'd1);
        check("t5c_inc0", 32'(pc_inc), 32'd0);
        exec_done = 1'b1;
        step(1);
        check("t5c_inc", 32'(pc_inc), 32'd1);
        exec_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t5c_park_req",  32'(rom_req), 32'd0);
            check("t5c_park_busy", 32'(busy),    32'd0);
        end

`ifdef TD4_FETCH_TIMEOUT_EN
        // 6. ROM timeout
        pc = 4'hA; run = 1'b1; rom_ack = 1'b0;
        step(1);
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check("t6_req", 32'(rom_req),   (i < 4) ? 32'd1 : 32'd0);
            check("t6_err", 32'(fetch_err), (i == 4) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t6_run_ignored", 32'(rom_req),   32'd0);
            check("t6_err_sticky",  32'(fetch_err), 32'd1);
        end
        #1 clr = 1'b1;
        #1;
        check("t6_err_clr", 32'(fetch_err), 32'd0);
        clr = 1'b0;
        step(1);
        check("t6_restart_req",  32'(rom_req),  32'd1);
        check("t6_restart_addr", 32'(rom_addr), 32'hA);
        rom_ack = 1'b1; rom_data = 8'h91;
        step(1);
        run = 1'b0; rom_ack = 1'b0; exec_done = 1'b1;
        step(1);
        check("t6_inc", 32'(pc_inc), 32'd1);
        exec_done = 1'b0;
`endif

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
